pll_ratio_ramp: RTL and testbench
=================================

Name: pll_ratio_ramp

Overview:
- Upstream sequencer for the PLL map core; converts CSR-level ratio change requests into the map core's write-strobe interface (valid, pll_enable, pll_ratiosel, pll_ratio, pll_vcodiv_ratio).
- Ramps the feedback ratio (sel=1) in bounded steps with a programmable dwell between writes, to avoid PLL lock loss.
- Post-divider writes (sel=2/3) are single-shot.
- Sequences PLL disable/re-enable, including the map core's post-reset/post-enable settling window.

Parameters:
- RATIO_W, 10, ratio width.
- DWELL_W, 16, dwell counter width.
- SETTLE_CYC, 4, cycles after reset/re-enable before any write is issued (map core needs 3 to reach its stable state).
- RST_RATIO, 10'hBC, shadow reset for feedback ratio.
- RST_ZDIV0, 10'hC7, shadow reset for zdiv0.
- RST_ZDIV1, 10'h19, shadow reset for zdiv1.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous reset, active-high.
- req_valid  in  1  request strobe.
- req_ready  out  1  high only in S_IDLE.
- req_sel  in  2  0=nop, 1=feedback ratio, 2=zdiv0, 3=zdiv1.
- req_ratio  in  RATIO_W  target value.
- req_vcodiv  in  2  vcodiv ratio sent with every write.
- cfg_step  in  5  max ratio delta per write; 0 is treated as 1.
- cfg_dwell  in  DWELL_W  idle cycles between ramp writes.
- cfg_pll_enable  in  1  level; desired PLL enable.
- valid  out  1  write strobe to the map core.
- pll_enable  out  1  to the map core.
- pll_ratiosel  out  2  to the map core.
- pll_ratio  out  RATIO_W  to the map core.
- pll_vcodiv_ratio  out  2  to the map core.
- busy  out  1  ~req_ready.
- done  out  1  one-cycle pulse when a request completes or is aborted.
- aborted  out  1  sticky; cleared on next request acceptance.

Behaviour:
- Clocking and reset: single clock; reset is synchronous and active-high (rst).
- Reset values: valid=0, pll_enable=1, ratiosel=0, ratio=0, vcodiv=0, done=0, aborted=0, req_ready=0. Shadows load RST_*; state=S_SETTLE, settle counter=SETTLE_CYC-1.
- Outputs are registered; valid is high for exactly one cycle per issued write. Data outputs hold their values after valid drops.
- Handshake: a request is accepted on req_valid & req_ready. req_* are captured at acceptance; cfg_step and cfg_dwell are sampled live.
- States:
  - S_SETTLE: count down; at 0 go to S_IDLE.
  - S_IDLE: req_ready=1.
    - cfg_pll_enable=0 goes to S_OFF; this takes priority over a simultaneous request, which is not accepted.
    - sel=0 accepted: done next cycle, no write.
    - sel=2/3 accepted: go to S_ISSUE with next=target.
    - sel=1 accepted: if target==shadow, done with no write; else go to S_ISSUE.
  - S_ISSUE: drive valid=1, pll_enable=1, ratiosel=sel, ratio=next, vcodiv; update shadow[sel]=next.
    - If next==target: done, go to S_IDLE.
    - Else go to S_DWELL, loading the dwell counter with cfg_dwell.
  - S_DWELL: when the counter reaches 0, compute the next step and go to S_ISSUE. cfg_dwell=0 gives back-to-back writes.
  - S_OFF: issue one valid=1 with pll_enable=0 (ratio/sel unchanged), then go to S_WAITEN.
  - S_WAITEN: wait for cfg_pll_enable=1, then go to S_SETTLE.
- Step rule: d=|target-shadow|, unsigned RATIO_W arithmetic, no wrap.
  - next = target if d<=step.
  - Otherwise next = shadow+step or shadow-step, as appropriate.
  - The final write always lands exactly on target.
- Abort: cfg_pll_enable=0 during S_ISSUE/S_DWELL finishes the current cycle's write (if any), then pulses done, sets aborted, and goes to S_OFF. The shadow keeps the last issued value.
- Mid-operation reset returns to S_SETTLE with shadows restored.
- Requests during S_SETTLE, S_OFF and S_WAITEN are not accepted (req_ready=0).

Optional Feature:
- Macro: PLL_RAMP_STATUS_EN.
- When defined, adds:
  - output wr_count[15:0]: count of issued writes, saturating at 0xFFFF, cleared by rst.
  - output cur_ratio[RATIO_W-1:0]: feedback shadow.
- When undefined, both ports and their logic are absent; all other behaviour is identical.

Decomposition:
- In pllMap_pkg: ratiosel encodings (SEL_NOP/SEL_RATIO/SEL_ZDIV0/SEL_ZDIV1), the RST_* defaults shared with the map core reset values, and the state enum typedef.
- Sub-module pll_ramp_step: combinational computation of next-ratio and is-last from (shadow, target, step).

Test Plan:
- Reset, then req_valid held high: req_ready rises 4 cycles after rst deasserts; no valid before then.
- sel=1, target 0xC4, step 3, dwell 2 from 0xBC: writes 0xBF, 0xC2, 0xC4 with 3-cycle spacing, then a single done pulse.
- sel=1, target 0xB0, step 0: twelve back-to-back writes descending by 1 when dwell=0; the last write is 0xB0.
- sel=2, ratio 0x50: exactly one valid with ratiosel=2; shadow zdiv0=0x50; a repeat request for 0xBC on sel=1 gives done with no valid.
- Mid-ramp cfg_pll_enable drops: the ramp stops, aborted=1, done pulse, one valid with pll_enable=0. Re-enable gives 4 settle cycles, then req_ready=1.
- With PLL_RAMP_STATUS_EN: wr_count matches the number of valid pulses; reset clears it to 0.

Source files
------------

// File: rtl/pllMap_pkg.sv
// Shared encodings, reset defaults and state type for the PLL ratio sequencer and map core.
package pllMap_pkg;

    localparam logic [1:0] SEL_NOP   = 2'd0;
    localparam logic [1:0] SEL_RATIO = 2'd1;
    localparam logic [1:0] SEL_ZDIV0 = 2'd2;
    localparam logic [1:0] SEL_ZDIV1 = 2'd3;

    // Must track the map core's own reset values so the shadows start in sync.
    localparam logic [9:0] PLL_RST_RATIO = 10'hBC;
    localparam logic [9:0] PLL_RST_ZDIV0 = 10'hC7;
    localparam logic [9:0] PLL_RST_ZDIV1 = 10'h19;

    typedef enum logic [2:0] {
        S_SETTLE,
        S_IDLE,
        S_ISSUE,
        S_DWELL,
        S_OFF,
        S_WAITEN
    } state_t;

endpackage

// File: rtl/pll_ramp_step.sv
// Next ramp value toward target, limited to step (0 treated as 1); purely combinational.
module pll_ramp_step #(
    parameter int RATIO_W = 10
) (
    input  logic [RATIO_W-1:0] shadow,
    input  logic [RATIO_W-1:0] target,
    input  logic [4:0]         step,
    output logic [RATIO_W-1:0] nxt_ratio,
    output logic               last
);

    logic [RATIO_W-1:0] eff;
    logic [RATIO_W-1:0] diff;
    logic               up;

    always_comb begin
        eff  = (step == 5'd0) ? RATIO_W'(1) : RATIO_W'(step);
        up   = target > shadow;
        diff = up ? (target - shadow) : (shadow - target);
        last = diff <= eff;
        // diff > eff on the non-final branches, so neither add nor subtract can wrap.
        if (last)
            nxt_ratio = target;
        else if (up)
            nxt_ratio = shadow + eff;
        else
            nxt_ratio = shadow - eff;
    end

endmodule

// File: rtl/pll_ratio_ramp.sv
// Sequences CSR ratio requests into map-core writes; feedback ratio ramped in bounded steps with dwell, ~2 cycles accept-to-first-write.
// Backpressure: req_ready only in idle. Define PLL_RAMP_STATUS_EN to add wr_count/cur_ratio status outputs.
module pll_ratio_ramp
    import pllMap_pkg::*;
#(
    parameter int                 RATIO_W    = 10,
    parameter int                 DWELL_W    = 16,
    parameter int                 SETTLE_CYC = 4,
    parameter logic [RATIO_W-1:0] RST_RATIO  = PLL_RST_RATIO,
    parameter logic [RATIO_W-1:0] RST_ZDIV0  = PLL_RST_ZDIV0,
    parameter logic [RATIO_W-1:0] RST_ZDIV1  = PLL_RST_ZDIV1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               req_valid,
    output logic               req_ready,
    input  logic [1:0]         req_sel,
    input  logic [RATIO_W-1:0] req_ratio,
    input  logic [1:0]         req_vcodiv,
    input  logic [4:0]         cfg_step,
    input  logic [DWELL_W-1:0] cfg_dwell,
    input  logic               cfg_pll_enable,
    output logic               valid,
    output logic               pll_enable,
    output logic [1:0]         pll_ratiosel,
    output logic [RATIO_W-1:0] pll_ratio,
    output logic [1:0]         pll_vcodiv_ratio,
    output logic               busy,
    output logic               done,
    output logic               aborted
`ifdef PLL_RAMP_STATUS_EN
    ,
    output logic [15:0]        wr_count,
    output logic [RATIO_W-1:0] cur_ratio
`endif
);

    state_t             state, state_d;
    logic [DWELL_W-1:0] cnt, cnt_d;
    logic [1:0]         sel_q, sel_d, vco_q, vco_d;
    logic [RATIO_W-1:0] tgt_q, tgt_d;
    logic [RATIO_W-1:0] sh_fb, sh_fb_d, sh_z0, sh_z0_d, sh_z1, sh_z1_d;
    logic               valid_d, en_d, done_d, abort_d;
    logic [1:0]         rsel_d, vcod_d;
    logic [RATIO_W-1:0] ratio_d;
    logic [RATIO_W-1:0] stp_next, wr_val;
    logic               stp_last, wr_last;

    pll_ramp_step #(.RATIO_W(RATIO_W)) u_step (
        .shadow    (sh_fb),
        .target    (tgt_q),
        .step      (cfg_step),
        .nxt_ratio (stp_next),
        .last      (stp_last)
    );

    assign wr_val    = (sel_q == SEL_RATIO) ? stp_next : tgt_q;
    assign wr_last   = (sel_q != SEL_RATIO) || stp_last;
    assign req_ready = (state == S_IDLE);
    assign busy      = ~req_ready;

    always_comb begin
        state_d = state;
        cnt_d   = cnt;
        sel_d   = sel_q;
        vco_d   = vco_q;
        tgt_d   = tgt_q;
        sh_fb_d = sh_fb;
        sh_z0_d = sh_z0;
        sh_z1_d = sh_z1;
        valid_d = 1'b0;
        en_d    = pll_enable;
        rsel_d  = pll_ratiosel;
        ratio_d = pll_ratio;
        vcod_d  = pll_vcodiv_ratio;
        done_d  = 1'b0;
        abort_d = aborted;
        case (state)
            S_SETTLE: begin
                if (cnt == '0)
                    state_d = S_IDLE;
                else
                    cnt_d = cnt - DWELL_W'(1);
            end
            S_IDLE: begin
                if (!cfg_pll_enable) begin
                    state_d = S_OFF;
                end else if (req_valid) begin
                    sel_d   = req_sel;
                    tgt_d   = req_ratio;
                    vco_d   = req_vcodiv;
                    abort_d = 1'b0;
                    if (req_sel == SEL_NOP || (req_sel == SEL_RATIO && req_ratio == sh_fb))
                        done_d = 1'b1;
                    else
                        state_d = S_ISSUE;
                end
            end
            S_ISSUE: begin
                valid_d = 1'b1;
                en_d    = 1'b1;
                rsel_d  = sel_q;
                ratio_d = wr_val;
                vcod_d  = vco_q;
                case (sel_q)
                    SEL_RATIO: sh_fb_d = wr_val;
                    SEL_ZDIV0: sh_z0_d = wr_val;
                    SEL_ZDIV1: sh_z1_d = wr_val;
                    default: ;
                endcase
                if (!cfg_pll_enable) begin
                    done_d  = 1'b1;
                    abort_d = 1'b1;
                    state_d = S_OFF;
                end else if (wr_last) begin
                    done_d  = 1'b1;
                    state_d = S_IDLE;
                end else if (cfg_dwell == '0) begin
                    state_d = S_ISSUE;
                end else begin
                    // Spacing between writes is cfg_dwell+1, so count one fewer here.
                    cnt_d   = cfg_dwell - DWELL_W'(1);
                    state_d = S_DWELL;
                end
            end
            S_DWELL: begin
                if (!cfg_pll_enable) begin
                    done_d  = 1'b1;
                    abort_d = 1'b1;
                    state_d = S_OFF;
                end else if (cnt == '0) begin
                    state_d = S_ISSUE;
                end else begin
                    cnt_d = cnt - DWELL_W'(1);
                end
            end
            S_OFF: begin
                valid_d = 1'b1;
                en_d    = 1'b0;
                state_d = S_WAITEN;
            end
            S_WAITEN: begin
                if (cfg_pll_enable) begin
                    en_d    = 1'b1;
                    cnt_d   = DWELL_W'(SETTLE_CYC - 1);
                    state_d = S_SETTLE;
                end
            end
            default: state_d = S_SETTLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state            <= S_SETTLE;
            cnt              <= DWELL_W'(SETTLE_CYC - 1);
            sel_q            <= SEL_NOP;
            vco_q            <= 2'd0;
            tgt_q            <= '0;
            sh_fb            <= RST_RATIO;
            sh_z0            <= RST_ZDIV0;
            sh_z1            <= RST_ZDIV1;
            valid            <= 1'b0;
            pll_enable       <= 1'b1;
            pll_ratiosel     <= SEL_NOP;
            pll_ratio        <= '0;
            pll_vcodiv_ratio <= 2'd0;
            done             <= 1'b0;
            aborted          <= 1'b0;
        end else begin
            state            <= state_d;
            cnt              <= cnt_d;
            sel_q            <= sel_d;
            vco_q            <= vco_d;
            tgt_q            <= tgt_d;
            sh_fb            <= sh_fb_d;
            sh_z0            <= sh_z0_d;
            sh_z1            <= sh_z1_d;
            valid            <= valid_d;
            pll_enable       <= en_d;
            pll_ratiosel     <= rsel_d;
            pll_ratio        <= ratio_d;
            pll_vcodiv_ratio <= vcod_d;
            done             <= done_d;
            aborted          <= abort_d;
        end
    end

`ifdef PLL_RAMP_STATUS_EN
    always_ff @(posedge clk) begin
        if (rst)
            wr_count <= '0;
        else if (valid_d && wr_count != 16'hFFFF)
            wr_count <= wr_count + 16'd1;
    end

    assign cur_ratio = sh_fb;
`endif

endmodule

// File: tb/tb_pll_ratio_ramp.sv
// Directed + randomized bench for pll_ratio_ramp against a write-list reference model.
module tb_pll_ratio_ramp;

    localparam int RW = 10;
    localparam int DW = 16;

    logic          clk = 1'b0;
    logic          rst, req_valid, req_ready, cfg_pll_enable;
    logic [1:0]    req_sel, req_vcodiv;
    logic [RW-1:0] req_ratio;
    logic [4:0]    cfg_step;
    logic [DW-1:0] cfg_dwell;
    logic          valid, pll_enable, busy, done, aborted;
    logic [1:0]    pll_ratiosel, pll_vcodiv_ratio;
    logic [RW-1:0] pll_ratio;
`ifdef PLL_RAMP_STATUS_EN
    logic [15:0]   wr_count;
    logic [RW-1:0] cur_ratio;
`endif

    pll_ratio_ramp dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
        .req_sel(req_sel), .req_ratio(req_ratio), .req_vcodiv(req_vcodiv),
        .cfg_step(cfg_step), .cfg_dwell(cfg_dwell), .cfg_pll_enable(cfg_pll_enable),
        .valid(valid), .pll_enable(pll_enable), .pll_ratiosel(pll_ratiosel),
        .pll_ratio(pll_ratio), .pll_vcodiv_ratio(pll_vcodiv_ratio),
        .busy(busy), .done(done), .aborted(aborted)
`ifdef PLL_RAMP_STATUS_EN
        , .wr_count(wr_count), .cur_ratio(cur_ratio)
`endif
    );

    always #5 clk = ~clk;

    int n_asrt = 0;
    int n_fail = 0;
    int cyc = 0, done_cnt = 0, done_cyc = 0, tot_valid = 0;
    logic [RW-1:0] q_ratio[$];
    logic [1:0]    q_sel[$];
    logic [1:0]    q_vco[$];
    logic          q_en[$];
    int            q_cyc[$];

    // Reference model: shadows and total expected write count.
    int m_fb, m_z0, m_z1, m_writes;
    int exp_q[$];

    always @(negedge clk) begin
        cyc++;
        if (rst) begin
            tot_valid = 0;
        end else if (valid) begin
            q_ratio.push_back(pll_ratio);
            q_sel.push_back(pll_ratiosel);
            q_vco.push_back(pll_vcodiv_ratio);
            q_en.push_back(pll_enable);
            q_cyc.push_back(cyc);
            tot_valid++;
        end
        if (done) begin
            done_cnt++;
            done_cyc = cyc;
        end
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_asrt++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, expv);
        end
    endtask

    task automatic clr_q();
        q_ratio.delete(); q_sel.delete(); q_vco.delete(); q_en.delete(); q_cyc.delete();
    endtask

    // Expected feedback writes: close the gap by at most step each write, last lands on target.
    function automatic void mk_ramp(input int sh, input int tgt, input int step);
        int eff, d;
        eff = (step == 0) ? 1 : step;
        exp_q.delete();
        while (sh != tgt) begin
            d = (tgt > sh) ? tgt - sh : sh - tgt;
            if (d <= eff) sh = tgt;
            else if (tgt > sh) sh = sh + eff;
            else sh = sh - eff;
            exp_q.push_back(sh);
        end
    endfunction

    task automatic do_reset(input logic hold);
        rst = 1'b1;
        req_valid = hold;
        req_sel = 2'd0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst valid", valid, 0);
        chk("rst pll_enable", pll_enable, 1);
        chk("rst ratiosel", pll_ratiosel, 0);
        chk("rst ratio", pll_ratio, 0);
        chk("rst vcodiv", pll_vcodiv_ratio, 0);
        chk("rst done", done, 0);
        chk("rst aborted", aborted, 0);
        chk("rst req_ready", req_ready, 0);
        chk("rst busy", busy, 1);
`ifdef PLL_RAMP_STATUS_EN
        chk("rst wr_count", wr_count, 0);
        chk("rst cur_ratio", cur_ratio, 10'hBC);
`endif
        clr_q();
        m_fb = 'hBC; m_z0 = 'hC7; m_z1 = 'h19; m_writes = 0;
        @(posedge clk);
        #1 rst = 1'b0;
        for (int k = 0; k <= 4; k++) begin
            @(negedge clk);
            chk("settle req_ready", req_ready, (k == 4) ? 1 : 0);
        end
        chk("settle no write", q_ratio.size(), 0);
        if (hold) begin
            @(posedge clk);
            #1 req_valid = 1'b0;
            @(negedge clk);
            chk("nop done", done, 1);
            chk("nop no write", valid, 0);
        end
    endtask

    task automatic wait_ready(input string tag);
        int w;
        w = 0;
        @(negedge clk);
        while (!req_ready && w < 200) begin
            @(negedge clk);
            w++;
        end
        chk({tag, " ready"}, req_ready, 1);
    endtask

    task automatic run_req(input string tag, input int sel, input int tgt, input int vco,
                           input int step, input int dwell);
        int w, d0, n;
        exp_q.delete();
        case (sel)
            1: begin mk_ramp(m_fb, tgt, step); m_fb = tgt; end
            2: begin exp_q.push_back(tgt); m_z0 = tgt; end
            3: begin exp_q.push_back(tgt); m_z1 = tgt; end
            default: ;
        endcase
        m_writes += exp_q.size();
        cfg_step = 5'(step);
        cfg_dwell = DW'(dwell);
        wait_ready(tag);
        clr_q();
        d0 = done_cnt;
        req_valid = 1'b1;
        req_sel = 2'(sel);
        req_ratio = RW'(tgt);
        req_vcodiv = 2'(vco);
        @(posedge clk);
        #1 req_valid = 1'b0;
        w = 0;
        while (done_cnt == d0 && w < 5000) begin
            @(negedge clk);
            w++;
        end
        repeat (dwell + 3) @(negedge clk);
        chk({tag, " done pulses"}, done_cnt - d0, 1);
        chk({tag, " write count"}, q_ratio.size(), exp_q.size());
        n = (q_ratio.size() < exp_q.size()) ? q_ratio.size() : exp_q.size();
        for (int i = 0; i < n; i++) begin
            chk({tag, " ratio"}, q_ratio[i], exp_q[i]);
            chk({tag, " sel"}, q_sel[i], sel);
            chk({tag, " vcodiv"}, q_vco[i], vco);
            chk({tag, " en"}, q_en[i], 1);
            if (i > 0) chk({tag, " spacing"}, q_cyc[i] - q_cyc[i-1], dwell + 1);
        end
        if (n > 0 && n == exp_q.size()) chk({tag, " done at last write"}, done_cyc, q_cyc[n-1]);
`ifdef PLL_RAMP_STATUS_EN
        chk({tag, " cur_ratio"}, cur_ratio, m_fb);
        chk({tag, " wr_count"}, wr_count, m_writes);
`endif
    endtask

    initial begin
        int t, s, nv, w;
        cfg_pll_enable = 1'b1;
        cfg_step = 5'd0;
        cfg_dwell = '0;
        req_ratio = '0;
        req_vcodiv = 2'd0;

        do_reset(1'b1);
        run_req("zdiv0", 2, 'h50, 1, 0, 0);
        run_req("same_fb", 1, 'hBC, 0, 0, 0);
        run_req("ramp_up", 1, 'hC4, 2, 3, 2);

        // Reset in the middle of a ramp must restore the shadows.
        cfg_step = 5'd1;
        cfg_dwell = '0;
        wait_ready("midrst");
        req_valid = 1'b1; req_sel = 2'd1; req_ratio = RW'('h10);
        @(posedge clk);
        #1 req_valid = 1'b0;
        repeat (5) @(negedge clk);
        do_reset(1'b0);
        run_req("ramp_dn", 1, 'hB0, 3, 0, 0);

        for (int r = 0; r < 8; r++) begin
            s = int'($urandom_range(0, 3));
            if (s == 1) begin
                t = m_fb + int'($urandom_range(0, 400)) - 200;
                if (t < 0) t = 0;
                if (t > 1023) t = 1023;
            end else begin
                t = int'($urandom_range(0, 1023));
            end
            run_req("rand", s, t, int'($urandom_range(0, 3)), int'($urandom_range(0, 31)),
                    int'($urandom_range(0, 3)));
        end

        // Abort: drop enable while dwelling after the third ramp write.
        t = (m_fb < 500) ? m_fb + 60 : m_fb - 60;
        mk_ramp(m_fb, t, 1);
        cfg_step = 5'd1;
        cfg_dwell = DW'(3);
        wait_ready("abort");
        clr_q();
        req_valid = 1'b1; req_sel = 2'd1; req_ratio = RW'(t); req_vcodiv = 2'd2;
        @(posedge clk);
        #1 req_valid = 1'b0;
        nv = 0; w = 0;
        while (nv < 3 && w < 200) begin
            @(negedge clk);
            if (valid) nv++;
            w++;
        end
        chk("abort ramp writes seen", nv, 3);
        cfg_pll_enable = 1'b0;
        @(negedge clk);
        chk("abort done", done, 1);
        chk("abort aborted", aborted, 1);
        chk("abort no write", valid, 0);
        @(negedge clk);
        chk("off valid", valid, 1);
        chk("off pll_enable", pll_enable, 0);
        chk("off ratiosel", pll_ratiosel, 1);
        chk("off ratio", pll_ratio, exp_q[2]);
        chk("off done", done, 0);
        repeat (6) @(negedge clk);
        chk("waiten writes", q_ratio.size(), 4);
        for (int i = 0; i < 3; i++) chk("abort ratio", q_ratio[i], exp_q[i]);
        chk("waiten req_ready", req_ready, 0);
        chk("waiten pll_enable", pll_enable, 0);
        chk("waiten aborted", aborted, 1);
        m_fb = exp_q[2];
        m_writes += 4;
        cfg_pll_enable = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk);
            chk("reen req_ready", req_ready, (k == 5) ? 1 : 0);
            if (k == 1) chk("reen pll_enable", pll_enable, 1);
        end
`ifdef PLL_RAMP_STATUS_EN
        chk("abort cur_ratio", cur_ratio, m_fb);
        chk("abort wr_count", wr_count, m_writes);
`endif
        run_req("after_abort", 0, 0, 0, 0, 0);
        chk("aborted cleared", aborted, 0);
        run_req("post_abort_ramp", 1, (m_fb < 500) ? m_fb + 7 : m_fb - 7, 1, 2, 1);
        chk("writes total", tot_valid, m_writes);

        $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
        $finish;
    end

endmodule
